// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver.
//
// Takes an asynchronous serial line, resynchronises it through two flops,
// takes a 3-sample majority vote around each mid-bit, rejects false starts,
// and delivers each received word with its own error flags on a valid/ready
// output register. If the held word has not been consumed when a new frame
// completes, the new frame is dropped and an overrun is flagged.
//
// Ports:
//   Clk_100M    in   system clock
//   Rst_n       in   synchronous reset, active-low
//   UART_Rx     in   asynchronous serial line, idle high
//   DATA        out  received word, LSB = first data bit on the line
//   VALID       out  DATA and the flags hold an unconsumed word
//   READY       in   consumer accepts the word when VALID & READY
//   BUSY        out  high while a frame is in progress
//   PARITY_ERR  out  parity mismatch for the held word
//   FRAME_ERR   out  a stop bit was sampled low for the held word
//   OVERRUN     out  a complete frame was dropped (held word not consumed)

module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 Clk_100M,
  input  logic                 Rst_n,
  input  logic                 UART_Rx,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 BUSY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB);

  localparam logic [CW-1:0] C_SMP0 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_SMP1 = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
  localparam logic [CW-1:0] C_END  = CW'(CPB - 1);

  localparam logic [3:0] C_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] C_LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Input synchroniser
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge Clk_100M) begin
    if (!Rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= UART_Rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive state machine
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_idx;
  logic                   r_smp0;
  logic                   r_smp1;
  logic                   r_armed;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_load;

  logic w_vote;
  logic w_decide;
  logic w_wrap;
  logic w_xor;
  logic w_par_bad;

  // Third sample is the live rx_s at the decision count.
  assign w_vote    = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
  assign w_decide  = (r_cnt == C_DEC);
  assign w_wrap    = (r_cnt == C_END);
  assign w_xor     = (^r_shift) ^ w_vote;
  assign w_par_bad = (PARITY == 1) ? ~w_xor : w_xor;

  always_ff @(posedge Clk_100M) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_smp0  <= 1'b0;
      r_smp1  <= 1'b0;
      r_armed <= 1'b0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_load  <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      r_load <= 1'b0;

      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end

      if (r_cnt == C_SMP0) r_smp0 <= r_rx_s;
      if (r_cnt == C_SMP1) r_smp1 <= r_rx_s;

      case (r_state)
        S_IDLE: begin
          // Re-arming only on a high line means a stuck-low line after a
          // framing error cannot retrigger start detection.
          if (!r_armed) begin
            if (r_rx_s) r_armed <= 1'b1;
          end else if (!r_rx_s) begin
            r_state <= S_START;
            r_armed <= 1'b0;
            r_idx   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            BUSY    <= 1'b1;
          end
        end

        S_START: begin
          if (w_decide && w_vote) begin
            r_state <= S_IDLE;
            BUSY    <= 1'b0;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_decide) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            if (r_idx == C_LAST_DATA) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (w_decide) r_perr <= w_par_bad;
          if (w_wrap) r_state <= S_STOP;
        end

        S_STOP: begin
          if (w_decide) begin
            if (!w_vote) r_ferr <= 1'b1;
            // Leave half a bit early so the next start edge is not missed.
            if (r_idx == C_LAST_STOP) begin
              r_state <= S_IDLE;
              BUSY    <= 1'b0;
              r_load  <= 1'b1;
            end
          end else if (w_wrap) begin
            r_idx <= r_idx + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake
  always_ff @(posedge Clk_100M) begin
    if (!Rst_n) begin
      DATA       <= '0;
      VALID      <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else if (r_load) begin
      if (!VALID || READY) begin
        DATA       <= r_shift;
        PARITY_ERR <= r_perr;
        FRAME_ERR  <= r_ferr;
        VALID      <= 1'b1;
        OVERRUN    <= 1'b0;
      end else begin
        OVERRUN <= 1'b1;
      end
    end else if (VALID && READY) begin
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end
  end

endmodule
